// File: rtl/cart_sram_backup.sv
// cart_sram_backup: copies cart battery SRAM to/from the HPS save image,
// one 512-byte sector at a time; owns the SRAM port whenever busy.
`timescale 1ns/1ps
module cart_sram_backup #(
   parameter int          SRAM_AW  = 13,
   parameter logic [31:0] LBA_BASE = 32'd0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load_req,
   input  logic               save_req,
   input  logic               cpu_sram_wr,
   output logic               busy,
   output logic               dirty,
   output logic [31:0]        sd_lba,
   output logic               sd_rd,
   output logic               sd_wr,
   input  logic               sd_ack,
   input  logic [8:0]         sd_buff_addr,
   input  logic [7:0]         sd_buff_dout,
   input  logic               sd_buff_wr,
   output logic [7:0]         sd_buff_din,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [7:0]         sram_wdata,
   output logic               sram_we,
   input  logic [7:0]         sram_rdata
);

   localparam int SW = SRAM_AW - 9;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      XFER,
      NEXT
   } state_t;

   state_t        state;
   logic          mode_load;
   logic [SW-1:0] sector;
   logic          ack_q;
   logic          last_sec;
   logic          in_xfer;

   assign last_sec = &sector;
   assign in_xfer  = (state == XFER) && sd_ack;
   assign busy     = (state != IDLE);

   assign sd_lba = LBA_BASE
                 + {{(32-SW){1'b0}}, sector};

   // HPS address steers SRAM only inside the ack window
   assign sram_addr  = in_xfer
                     ? {sector, sd_buff_addr}
                     : {sector, 9'd0};
   assign sram_wdata = sd_buff_dout;
   assign sram_we    = in_xfer && mode_load
                     && sd_buff_wr;

   // SRAM read latency alone gives the 1-clk byte delay
   assign sd_buff_din =
      (state == XFER && !mode_load)
      ? sram_rdata : 8'd0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         mode_load <= 1'b0;
         sector    <= '0;
         ack_q     <= 1'b0;
         sd_rd     <= 1'b0;
         sd_wr     <= 1'b0;
         dirty     <= 1'b0;
      end else begin
         ack_q <= sd_ack;

         // a CPU write always beats the completion clear
         if (cpu_sram_wr)
            dirty <= 1'b1;
         else if (state == NEXT && last_sec)
            dirty <= 1'b0;

         unique case (state)
            IDLE: begin
               if (load_req) begin
                  mode_load <= 1'b1;
                  sector    <= '0;
                  sd_rd     <= 1'b1;
                  state     <= REQ;
               end else if (save_req) begin
                  mode_load <= 1'b0;
                  sector    <= '0;
                  sd_wr     <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (sd_ack) begin
                  sd_rd <= 1'b0;
                  sd_wr <= 1'b0;
                  state <= XFER;
               end
            end
            XFER: begin
               if (ack_q && !sd_ack)
                  state <= NEXT;
            end
            NEXT: begin
               if (last_sec) begin
                  state <= IDLE;
               end else begin
                  sector <= sector + SW'(1);
                  sd_rd  <= mode_load;
                  sd_wr  <= !mode_load;
                  state  <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cart_sram_backup.sv
// tb_cart_sram_backup: directed vectors plus full-image save/load
// sequences against an HPS model and a registered SRAM model.
`timescale 1ns/1ps
module tb_cart_sram_backup;

   localparam bit O = 1'b0;
   localparam bit I = 1'b1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        load_req = 1'b0;
   logic        save_req = 1'b0;
   logic        cpu_sram_wr = 1'b0;
   logic        sd_ack = 1'b0;
   logic [8:0]  sd_buff_addr = '0;
   logic [7:0]  sd_buff_dout = '0;
   logic        sd_buff_wr = 1'b0;
   logic        busy, dirty, sd_rd, sd_wr;
   logic [31:0] sd_lba;
   logic [7:0]  sd_buff_din, sram_wdata;
   logic [7:0]  sram_rdata;
   logic [12:0] sram_addr;
   logic        sram_we;

   logic        save_req2 = 1'b0;
   logic        sd_ack2 = 1'b0;
   logic        busy2, dirty2, sd_rd2, sd_wr2;
   logic        sram_we2;
   logic [31:0] sd_lba2;
   logic [7:0]  sd_buff_din2, sram_wdata2;
   logic [7:0]  sram_rdata2;
   logic [9:0]  sram_addr2;

   logic        pre_we = 1'b0;
   logic [12:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;
   logic [7:0]  mem [8192];

   int checks = 0;
   int failures = 0;
   int we_bad = 0;
   int wr_cycles = 0;
   bit we_ok = 1'b0;

   typedef struct {
      bit ld, sv, cw, ack;
      bit busy, rd, wr, dirty;
      logic [31:0] lba;
   } vec_t;
   vec_t vt [11];

   always #5 clk = ~clk;

   cart_sram_backup u_dut (
      .clk(clk), .reset_n(reset_n),
      .load_req(load_req), .save_req(save_req),
      .cpu_sram_wr(cpu_sram_wr),
      .busy(busy), .dirty(dirty),
      .sd_lba(sd_lba), .sd_rd(sd_rd),
      .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr),
      .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr),
      .sd_buff_din(sd_buff_din),
      .sram_addr(sram_addr),
      .sram_wdata(sram_wdata),
      .sram_we(sram_we),
      .sram_rdata(sram_rdata)
   );

   cart_sram_backup #(
      .SRAM_AW(10), .LBA_BASE(32'h100)
   ) u_dut2 (
      .clk(clk), .reset_n(reset_n),
      .load_req(1'b0), .save_req(save_req2),
      .cpu_sram_wr(1'b0),
      .busy(busy2), .dirty(dirty2),
      .sd_lba(sd_lba2), .sd_rd(sd_rd2),
      .sd_wr(sd_wr2), .sd_ack(sd_ack2),
      .sd_buff_addr(9'd0),
      .sd_buff_dout(8'd0),
      .sd_buff_wr(1'b0),
      .sd_buff_din(sd_buff_din2),
      .sram_addr(sram_addr2),
      .sram_wdata(sram_wdata2),
      .sram_we(sram_we2),
      .sram_rdata(sram_rdata2)
   );

   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (sram_we)
         mem[sram_addr] <= sram_wdata;
      sram_rdata  <= mem[sram_addr];
      sram_rdata2 <= sram_addr2[7:0];
   end

   always @(posedge clk) begin
      #1;
      if (sram_we && !we_ok) we_bad++;
      if (sd_wr) wr_cycles++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: no finish");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] pat(int a);
      return a[7:0] ^ {3'b0, a[12:8]};
   endfunction

   function automatic logic [7:0] ld_byte(int l, int a);
      return 8'(l * 7 + a);
   endfunction

   function automatic logic [7:0] exp_byte(
      bit sel, int s, int i);
      return sel ? ld_byte(s, i)
                 : pat(s * 512 + i);
   endfunction

   task automatic chk(input string name,
      input logic [31:0] act,
      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h",
            name, act, exp);
      end
   endtask

   task automatic wait_req(input bit ld,
      output bit ok);
      int n = 0;
      while (((ld ? sd_rd : sd_wr) !== 1'b1)
             && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = (n < 50);
   endtask

   task automatic serve(input bit ld,
      input int sec, input bit sel);
      bit ok;
      int bad;
      wait_req(ld, ok);
      chk("req_seen", 32'(ok), 32'd1);
      if (!ok) return;
      chk("sd_lba", sd_lba, 32'(sec));
      chk("other_req",
         32'(ld ? sd_wr : sd_rd), 32'd0);
      // stray strobe while still in REQ
      sd_buff_dout = 8'hEE;
      sd_buff_wr = 1'b1;
      @(negedge clk);
      sd_buff_wr = !ld;
      sd_buff_dout = 8'hA5;
      sd_ack = 1'b1;
      sd_buff_addr = '0;
      @(negedge clk);
      chk("req_drop",
         32'(ld ? sd_rd : sd_wr), 32'd0);
      bad = 0;
      if (ld) begin
         we_ok = 1'b1;
         for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            sd_buff_dout = ld_byte(sec, i);
            sd_buff_wr = 1'b1;
            @(negedge clk);
         end
         we_ok = 1'b0;
      end else begin
         for (int k = 1; k <= 512; k++) begin
            if (sd_buff_din !==
                exp_byte(sel, sec, k - 1))
               bad++;
            if (k < 512) begin
               sd_buff_addr = 9'(k);
               @(negedge clk);
            end
         end
         chk("save_data", 32'(bad), 32'd0);
      end
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic run(input bit ld,
      input bit sel, input bit cw_final);
      for (int s = 0; s < 16; s++) begin
         serve(ld, s, sel);
         if (ld && s == 2) begin
            save_req = 1'b1;
            @(negedge clk);
            save_req = 1'b0;
         end
      end
      cpu_sram_wr = cw_final;
      @(negedge clk);
      cpu_sram_wr = 1'b0;
      chk("end_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      bit ok;
      int bad;
      int n;
      vt[0]  = '{O,O,O,O, O,O,O,O, 32'd0};
      vt[1]  = '{O,O,I,O, O,O,O,I, 32'd0};
      vt[2]  = '{O,I,O,O, I,O,I,I, 32'd0};
      vt[3]  = '{I,O,O,O, I,O,I,I, 32'd0};
      vt[4]  = '{O,O,O,I, I,O,O,I, 32'd0};
      vt[5]  = '{O,O,O,I, I,O,O,I, 32'd0};
      vt[6]  = '{O,O,O,O, I,O,O,I, 32'd0};
      vt[7]  = '{O,O,O,O, I,O,I,I, 32'd1};
      vt[8]  = '{O,O,O,I, I,O,O,I, 32'd1};
      vt[9]  = '{O,O,O,O, I,O,O,I, 32'd1};
      vt[10] = '{O,O,O,O, I,O,I,I, 32'd2};

      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dirty", 32'(dirty), 32'd0);
      chk("rst_rd", 32'(sd_rd), 32'd0);
      chk("rst_wr", 32'(sd_wr), 32'd0);
      chk("rst_lba", sd_lba, 32'd0);
      chk("rst_din", 32'(sd_buff_din), 32'd0);
      chk("rst_we", 32'(sram_we), 32'd0);
      chk("rst_lba2", sd_lba2, 32'h100);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         load_req = vt[i].ld;
         save_req = vt[i].sv;
         cpu_sram_wr = vt[i].cw;
         sd_ack = vt[i].ack;
         @(negedge clk);
         chk($sformatf("v%0d_busy", i),
            32'(busy), 32'(vt[i].busy));
         chk($sformatf("v%0d_rd", i),
            32'(sd_rd), 32'(vt[i].rd));
         chk($sformatf("v%0d_wr", i),
            32'(sd_wr), 32'(vt[i].wr));
         chk($sformatf("v%0d_dirty", i),
            32'(dirty), 32'(vt[i].dirty));
         chk($sformatf("v%0d_lba", i),
            sd_lba, vt[i].lba);
      end
      load_req = 1'b0;
      save_req = 1'b0;
      cpu_sram_wr = 1'b0;
      sd_ack = 1'b0;

      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_wr", 32'(sd_wr), 32'd0);
      chk("arst_dirty", 32'(dirty), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int a = 0; a < 8192; a++) begin
         pre_addr = 13'(a);
         pre_data = pat(a);
         pre_we = 1'b1;
         @(negedge clk);
      end
      pre_we = 1'b0;

      cpu_sram_wr = 1'b1;
      @(negedge clk);
      cpu_sram_wr = 1'b0;
      chk("idle_dirty", 32'(dirty), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      we_bad = 0;
      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      run(1'b0, 1'b0, 1'b0);
      chk("save_dirty", 32'(dirty), 32'd0);
      chk("save_we", 32'(we_bad), 32'd0);

      cpu_sram_wr = 1'b1;
      @(negedge clk);
      cpu_sram_wr = 1'b0;
      wr_cycles = 0;
      load_req = 1'b1;
      save_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      save_req = 1'b0;
      chk("both_rd", 32'(sd_rd), 32'd1);
      chk("both_wr", 32'(sd_wr), 32'd0);
      run(1'b1, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      chk("load_busy", 32'(busy), 32'd0);
      chk("load_rd", 32'(sd_rd), 32'd0);
      chk("load_wrcyc", 32'(wr_cycles), 32'd0);
      chk("load_we", 32'(we_bad), 32'd0);
      chk("load_dirty", 32'(dirty), 32'd0);
      for (int s = 0; s < 16; s++) begin
         bad = 0;
         for (int i = 0; i < 512; i++)
            if (mem[s * 512 + i] !==
                ld_byte(s, i))
               bad++;
         chk($sformatf("load_sec%0d", s),
            32'(bad), 32'd0);
      end

      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      for (int s = 0; s < 5; s++)
         serve(1'b0, s, 1'b1);
      wait_req(1'b0, ok);
      chk("s5_req", 32'(ok), 32'd1);
      chk("s5_lba", sd_lba, 32'd5);
      sd_ack = 1'b1;
      sd_buff_addr = '0;
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         sd_buff_addr = 9'(i);
      end
      chk("s5_busy", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_wr", 32'(sd_wr), 32'd0);
      chk("mid_we", 32'(sram_we), 32'd0);
      sd_ack = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      run(1'b0, 1'b1, 1'b1);
      chk("coinc_dirty", 32'(dirty), 32'd1);

      save_req2 = 1'b1;
      @(negedge clk);
      save_req2 = 1'b0;
      for (int s = 0; s < 2; s++) begin
         n = 0;
         while (sd_wr2 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("d2_req", 32'(n < 50), 32'd1);
         chk("d2_lba", sd_lba2, 32'h100 + 32'(s));
         sd_ack2 = 1'b1;
         repeat (3) @(negedge clk);
         chk("d2_drop", 32'(sd_wr2), 32'd0);
         sd_ack2 = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
      chk("d2_busy", 32'(busy2), 32'd0);
      repeat (5) @(negedge clk);
      chk("d2_idle_wr", 32'(sd_wr2), 32'd0);
      chk("d2_idle_busy", 32'(busy2), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d",
         checks, failures);
      $finish;
   end

endmodule
